// File: rtl/icb_apb_pkg.sv
`default_nettype none
// ============================================================================
// icb_apb_pkg : FSM states, status codes and command layout for icb_apb_master
// Rev 1.0
// ============================================================================
package icb_apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD_REQ = 3'd1,
    ST_CMD_LAT = 3'd2,
    ST_DAT_REQ = 3'd3,
    ST_DAT_LAT = 3'd4,
    ST_SETUP   = 3'd5,
    ST_ACCESS  = 3'd6
  } apb_fsm_e;

  localparam logic [1:0] APB_ST_IDLE   = 2'b00;
  localparam logic [1:0] APB_ST_SETUP  = 2'b01;
  localparam logic [1:0] APB_ST_ACCESS = 2'b10;
  localparam logic [1:0] APB_ST_FETCH  = 2'b11;

  localparam int CMD_ADDR_LSB  = 8;
  localparam int CMD_ADDR_W    = 24;
  localparam int CMD_WRITE_BIT = 1;
  localparam int CMD_SEL_LSB   = 2;
  localparam int CMD_SEL_W     = 4;
  localparam int N_SLAVES      = 4;

  localparam logic [31:0] ABORT_RDATA = 32'hFFFF_FFFF;

  function automatic logic [1:0] apb_state_code(input apb_fsm_e st);
    case (st)
      ST_IDLE:   return APB_ST_IDLE;
      ST_SETUP:  return APB_ST_SETUP;
      ST_ACCESS: return APB_ST_ACCESS;
      default:   return APB_ST_FETCH;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_slave_mux.sv
`default_nettype none
// ============================================================================
// apb_slave_mux : one-hot select decode to psel, prdata/pready return mux
// Rev 1.0
// ============================================================================
module apb_slave_mux
  import icb_apb_pkg::*;
(
  input  logic [CMD_SEL_W-1:0]         sel,
  output logic                         sel_ok,
  output logic [N_SLAVES-1:0]          psel_dec,
  input  logic [N_SLAVES-1:0]          psel,
  input  logic [N_SLAVES-1:0][31:0]    prdata,
  input  logic [N_SLAVES-1:0]          pready,
  output logic [31:0]                  sel_prdata,
  output logic                         sel_pready
);

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero
  assign sel_ok   = (sel != '0) &&
                    ((sel & (sel - {{(CMD_SEL_W-1){1'b0}}, 1'b1})) == '0);
  assign psel_dec = sel_ok ? sel : '0;

  always_comb begin
    sel_prdata = '0;
    sel_pready = 1'b0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (psel[i]) begin
        sel_prdata = prdata[i];
        sel_pready = pready[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/icb_apb_master.sv
`default_nettype none
// ============================================================================
// icb_apb_master : pops commands from wfifo, runs one APB transfer at a time,
//                  pushes read data to rfifo. Optional macro: APB_TIMEOUT_EN.
// Rev 1.0
// ============================================================================
module icb_apb_master
  import icb_apb_pkg::*;
`ifdef APB_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
)
`endif
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [63:0]               control,
  input  logic                      wfifo_empty,
  input  logic [31:0]               wfifo_rdata,
  input  logic                      rfifo_full,
  output logic                      wfifo_ren,
  output logic                      rfifo_wen,
  output logic [31:0]               rdata,
  output logic [1:0]                apb_state,
  output logic [N_SLAVES-1:0]       psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [31:0]               paddr,
  output logic [31:0]               pwdata,
  input  logic [N_SLAVES-1:0][31:0] prdata,
  input  logic [N_SLAVES-1:0]       pready
);

  apb_fsm_e                state_q, state_d;
  logic [CMD_ADDR_W-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [CMD_SEL_W-1:0]    sel_q, sel_d;
  logic                    cmd_vld_q, cmd_vld_d;
  logic [N_SLAVES-1:0]     psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [31:0]             paddr_q, paddr_d;
  logic [31:0]             pwdata_q, pwdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    alive_q;

  logic                    enable_w;
  logic [CMD_ADDR_W-1:0]   addr_w;
  logic                    write_w;
  logic [CMD_SEL_W-1:0]    sel_w;
  logic                    sel_ok_w;
  logic [N_SLAVES-1:0]     psel_dec_w;
  logic [31:0]             sel_prdata_w;
  logic                    sel_pready_w;
  logic                    timeout_w;
  logic                    ren_w;
  logic                    wen_w;

  assign enable_w = control[0];

  // First CMD_LAT cycle decodes straight from the FIFO; a stalled read then uses the latched copy
  always_comb begin
    if (state_q == ST_CMD_LAT && !cmd_vld_q) begin
      addr_w  = wfifo_rdata[CMD_ADDR_LSB +: CMD_ADDR_W];
      write_w = wfifo_rdata[CMD_WRITE_BIT];
      sel_w   = wfifo_rdata[CMD_SEL_LSB +: CMD_SEL_W];
    end else begin
      addr_w  = addr_q;
      write_w = write_q;
      sel_w   = sel_q;
    end
  end

  apb_slave_mux u_slave_mux (
    .sel        (sel_w),
    .sel_ok     (sel_ok_w),
    .psel_dec   (psel_dec_w),
    .psel       (psel_q),
    .prdata     (prdata),
    .pready     (pready),
    .sel_prdata (sel_prdata_w),
    .sel_pready (sel_pready_w)
  );

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign timeout_w = (state_q == ST_ACCESS) && !sel_pready_w &&
                     (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == ST_ACCESS && !sel_pready_w)
      tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
  end
`else
  assign timeout_w = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    sel_d     = sel_q;
    cmd_vld_d = cmd_vld_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    ren_w     = 1'b0;
    wen_w     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (alive_q && enable_w && !wfifo_empty) begin
          ren_w   = 1'b1;
          state_d = ST_CMD_LAT;
        end
      end
      ST_CMD_LAT: begin
        addr_d    = addr_w;
        write_d   = write_w;
        sel_d     = sel_w;
        cmd_vld_d = 1'b1;
        if (write_w) begin
          cmd_vld_d = 1'b0;
          state_d   = ST_DAT_REQ;
        end else if (!sel_ok_w) begin
          cmd_vld_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (!rfifo_full) begin
          cmd_vld_d = 1'b0;
          psel_d    = psel_dec_w;
          pwrite_d  = 1'b0;
          paddr_d   = {8'h00, addr_w};
          state_d   = ST_SETUP;
        end
      end
      ST_DAT_REQ: begin
        if (!wfifo_empty) begin
          ren_w   = 1'b1;
          state_d = ST_DAT_LAT;
        end
      end
      ST_DAT_LAT: begin
        // Data word is consumed either way; a bad select just drops the command
        if (sel_ok_w) begin
          pwdata_d = wfifo_rdata;
          psel_d   = psel_dec_w;
          pwrite_d = 1'b1;
          paddr_d  = {8'h00, addr_w};
          state_d  = ST_SETUP;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (sel_pready_w || timeout_w) begin
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = ST_IDLE;
          if (!pwrite_q) begin
            rdata_d = sel_pready_w ? sel_prdata_w : ABORT_RDATA;
            wen_w   = !rfifo_full;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      sel_q     <= '0;
      cmd_vld_q <= 1'b0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      alive_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      sel_q     <= sel_d;
      cmd_vld_q <= cmd_vld_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      alive_q   <= 1'b1;
`ifdef APB_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

  // Pop strobe is held off until the first clock after reset release
  assign wfifo_ren = ren_w;
  assign rfifo_wen = wen_w;
  assign rdata     = wen_w ? rdata_d : rdata_q;
  assign apb_state = apb_state_code(state_q);
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_icb_apb_master.sv
`default_nettype none
// ============================================================================
// tb_icb_apb_master : directed bench with a transfer-level expectation queue
// Rev 1.0
// ============================================================================
module tb_icb_apb_master;

  logic             clk;
  logic             rst_n;
  logic [63:0]      control;
  logic             wfifo_empty;
  logic [31:0]      wfifo_rdata;
  logic             rfifo_full;
  logic             wfifo_ren;
  logic             rfifo_wen;
  logic [31:0]      rdata;
  logic [1:0]       apb_state;
  logic [3:0]       psel;
  logic             penable;
  logic             pwrite;
  logic [31:0]      paddr;
  logic [31:0]      pwdata;
  logic [3:0][31:0] prdata;
  logic [3:0]       pready;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } xfer_t;

  xfer_t       exp_q[$];
  logic [31:0] wq[$];
  xfer_t       cur;

  int n_pass = 0, n_total = 0;
  int cyc = 0, n_done = 0, n_wen = 0, t_start = 0;
  int last_lat = 0, last_acc = 0, acc_run = 0, acc_wait = 0, slv_wait = 0;
  bit pop_pending = 0, ready_now = 0;

  icb_apb_master dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .control     (control),
    .wfifo_empty (wfifo_empty),
    .wfifo_rdata (wfifo_rdata),
    .rfifo_full  (rfifo_full),
    .wfifo_ren   (wfifo_ren),
    .rfifo_wen   (rfifo_wen),
    .rdata       (rdata),
    .apb_state   (apb_state),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, expv);
  endtask

  // Queue a command (and data word for writes); a valid one-hot select yields one expected transfer
  task automatic send_cmd(input logic [23:0] addr, input logic [7:0] lo, input logic [31:0] data);
    xfer_t      x;
    logic [3:0] sel;
    int         idx;
    wq.push_back({addr, lo});
    if (lo[1]) wq.push_back(data);
    sel = lo[5:2];
    idx = 0;
    for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
    if ($countones(sel) == 1) begin
      x.sel   = sel;
      x.addr  = {8'h00, addr};
      x.write = lo[1];
      x.wdata = data;
      x.rdata = prdata[idx];
      exp_q.push_back(x);
    end
  endtask

  // FIFO/slave responder plus per-cycle comparison against the expectation queue
  initial begin : monitor
    pready      = 4'b0;
    wfifo_empty = 1'b1;
    wfifo_rdata = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pop_pending && wq.size() > 0) wfifo_rdata = wq.pop_front();
      pop_pending = 1'b0;
      wfifo_empty = (wq.size() == 0);
      if (psel != 4'b0 && penable) begin
        ready_now = (acc_wait >= slv_wait);
        acc_wait++;
      end else begin
        ready_now = 1'b0;
        acc_wait  = 0;
      end
      pready = ~psel | (ready_now ? psel : 4'b0);
      #3;
      chk("ren_while_empty", wfifo_ren & wfifo_empty, 0);
      chk("wen_while_full", rfifo_wen & rfifo_full, 0);
      if (rfifo_wen) n_wen++;
      if (wfifo_ren && apb_state == 2'b00) t_start = cyc;
      if (psel != 4'b0) begin
        chk("apb_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          cur = exp_q[0];
          chk("psel", psel, cur.sel);
          chk("paddr", paddr, cur.addr);
          chk("pwrite", pwrite, cur.write);
          if (cur.write) chk("pwdata", pwdata, cur.wdata);
          chk("apb_state_xfer", apb_state, penable ? 2'b10 : 2'b01);
          if (penable) begin
            acc_run++;
            if (ready_now) begin
              chk("wen_done", rfifo_wen, cur.write ? 32'd0 : 32'd1);
              if (!cur.write) chk("rdata_done", rdata, cur.rdata);
              last_lat = cyc - t_start + 1;
              last_acc = acc_run;
              n_done++;
              void'(exp_q.pop_front());
            end else begin
              chk("wen_wait", rfifo_wen, 0);
            end
          end else begin
            acc_run = 0;
          end
        end
      end else begin
        chk("penable_idle", penable, 0);
        chk("wen_idle", rfifo_wen, 0);
        acc_run = 0;
      end
      pop_pending = wfifo_ren;
    end
  end

  task automatic wait_setup(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #4;
      if (psel != 4'b0) break;
    end
    chk("setup_seen", psel != 4'b0, 1);
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #4;
      if (apb_state == s) break;
    end
    chk("state_seen", apb_state, s);
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (n_done >= target) break;
      @(negedge clk); #4;
    end
    chk("done_count", n_done, target);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wfifo_ren"}, wfifo_ren, 0);
    chk({tag, "_rfifo_wen"}, rfifo_wen, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_apb_state"}, apb_state, 0);
    chk({tag, "_psel"}, psel, 0);
    chk({tag, "_penable"}, penable, 0);
    chk({tag, "_pwrite"}, pwrite, 0);
    chk({tag, "_paddr"}, paddr, 0);
    chk({tag, "_pwdata"}, pwdata, 0);
  endtask

  initial begin : stim
    rst_n      = 1'b1;
    control    = 64'h0;
    rfifo_full = 1'b0;
    prdata[0]  = 32'hDEAD_0000;
    prdata[1]  = 32'hDEAD_0001;
    prdata[2]  = 32'hDEAD_0002;
    prdata[3]  = 32'hDEAD_0003;
    #1 rst_n = 1'b0;
    #11;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write slave0, zero-wait
    control  = 64'h1;
    slv_wait = 0;
    send_cmd(24'h000001, 8'h06, 32'h11);
    wait_setup(20);
    chk("t1_psel", psel, 4'b0001);
    chk("t1_paddr", paddr, 32'h1);
    chk("t1_pwrite", pwrite, 1);
    chk("t1_pwdata", pwdata, 32'h11);
    wait_done(1, 20);
    chk("t1_latency", last_lat, 6);
    chk("t1_no_wen", n_wen, 0);

    // Write slave1 with two wait cycles; enable drops mid-transfer
    @(negedge clk);
    slv_wait = 2;
    send_cmd(24'h000002, 8'h0A, 32'h0F);
    wait_setup(20);
    chk("t2_psel", psel, 4'b0010);
    @(negedge clk);
    control   = 64'h0;
    prdata[0] = 32'h6;
    send_cmd(24'h000003, 8'h04, 32'h0);
    wait_done(2, 40);
    chk("t2_access_cycles", last_acc, 3);
    repeat (6) @(negedge clk);
    #4;
    chk("t2_gated_queue", wq.size(), 1);
    chk("t2_gated_state", apb_state, 2'b00);

    // Read slave0 once re-enabled
    @(negedge clk);
    slv_wait = 0;
    control  = 64'h1;
    wait_done(3, 20);
    chk("t3_latency", last_lat, 4);
    chk("t3_rdata", rdata, 32'h6);
    chk("t3_wen_count", n_wen, 1);

    // Read slave2 stalled by a full rfifo
    @(negedge clk);
    rfifo_full = 1'b1;
    prdata[2]  = 32'hA5A5_0002;
    send_cmd(24'h000004, 8'h10, 32'h0);
    repeat (8) @(negedge clk);
    #4;
    chk("t4_stall_state", apb_state, 2'b11);
    chk("t4_stall_psel", psel, 4'b0);
    @(negedge clk);
    rfifo_full = 1'b0;
    wait_done(4, 20);
    chk("t4_rdata", rdata, 32'hA5A5_0002);
    chk("t4_wen_count", n_wen, 2);

    // Gating, then invalid selects (none set on a write, two set on a read)
    @(negedge clk);
    control = 64'h0;
    send_cmd(24'h000005, 8'h02, 32'h77);
    send_cmd(24'h000007, 8'h0C, 32'h0);
    repeat (6) @(negedge clk);
    #4;
    chk("t5_gated_queue", wq.size(), 3);
    @(negedge clk);
    control = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (14) @(negedge clk);
    #4;
    chk("t5_drained", wq.size(), 0);
    chk("t5_no_xfer", n_done, 4);
    chk("t5_state", apb_state, 2'b00);
    chk("t5_wen_count", n_wen, 2);

    // Reset asserted in the middle of ACCESS
    @(negedge clk);
    slv_wait  = 1000;
    prdata[3] = 32'h3333_3333;
    send_cmd(24'h000006, 8'h20, 32'h0);
    wait_state(2'b10, 20);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    slv_wait = 0;
    repeat (3) @(negedge clk);
    #4;
    chk("post_rst_state", apb_state, 2'b00);
    chk("post_rst_psel", psel, 4'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
`default_nettype wire
